// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word fall-through receive FIFO.
// Handles a configurable frame (data width, parity, stop bits). Error flags are sticky.
// The consumer reads through a valid/ready interface.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQUENCY = 500_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                          CLK,
    input  logic                          NRST,
    input  logic                          UART_RX_DSER,
    output logic [DATA_BITS-1:0]          RDATA,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          PARITY_ERR,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN,
    input  logic                          ERR_CLR
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    // Reject parameter sets the datapath cannot support.
    if (CLKS_PER_BIT < 4) begin : g_chk_baud
        $error("uart_rx_fifo: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_chk_parity
        $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StBreak
    } state_e;

    // Synchroniser and edge-detect history
    logic rx_meta_q, rxs_q, rxs_prev_q;

    // Receiver state
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_pend_q, par_pend_d;

    // Frame-level events from the receiver
    logic push, frame_evt, parity_evt;
    logic cnt_done;

    // FIFO storage and control
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 rvalid, full, pop, push_ok, overrun_evt;

    // Sticky error flags
    logic parity_err_q, parity_err_d;
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    // Two-flop synchroniser plus one history flop for start-edge detection
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= UART_RX_DSER;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign cnt_done = (cnt_q == '0);

    // Receiver next-state: bit timing, sampling, parity and stop checks
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_pend_d = par_pend_q;
        push       = 1'b0;
        frame_evt  = 1'b0;
        parity_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = StStart;
                    cnt_d   = CNT_HALF;
                end
            end
            StStart: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs_q) begin
                    // Line back high at mid start bit: treat as a glitch
                    state_d = StIdle;
                end else begin
                    state_d    = StData;
                    cnt_d      = CNT_FULL;
                    bit_idx_d  = '0;
                    par_pend_d = 1'b0;
                end
            end
            StData: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Shift in at the top so the first bit ends at the LSB
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            StPar: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_pend_d = ((^shift_q) ^ rxs_q) != PAR_ODD;
                    cnt_d      = CNT_FULL;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rxs_q) begin
                    frame_evt = 1'b1;
                    state_d   = StBreak;
                end else if (stop_idx_q == LAST_STOP) begin
                    // Return to idle at mid stop bit so a following start edge is not missed
                    if (par_pend_q) begin
                        parity_evt = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    stop_idx_d = 1'b1;
                    cnt_d      = CNT_FULL;
                end
            end
            StBreak: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_pend_q <= par_pend_d;
        end
    end

    // FIFO control: simultaneous push and pop on a full FIFO are both accepted
    always_comb begin
        rvalid      = (count_q != '0);
        full        = (count_q == OCC_FULL);
        pop         = rvalid && RREADY;
        push_ok     = push && (!full || pop);
        overrun_evt = push && full && !pop;
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    // FIFO storage; read data is gated by occupancy so it needs no reset
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sticky flags: a new event wins over a coincident clear
    always_comb begin
        parity_err_d = (parity_err_q && !ERR_CLR) || parity_evt;
        frame_err_d  = (frame_err_q && !ERR_CLR) || frame_evt;
        overrun_d    = (overrun_q && !ERR_CLR) || overrun_evt;
    end

    // Sticky flag registers
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign RDATA      = rvalid ? mem_q[rd_ptr_q] : '0;
    assign RVALID     = rvalid;
    assign FIFO_COUNT = count_q;
    assign PARITY_ERR = parity_err_q;
    assign FRAME_ERR  = frame_err_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an even-parity instance,
// both at 10 clocks per bit.
module tb_uart_rx_fifo;

    logic       clk;
    logic       nrst;
    logic       rx, rx_p;
    logic       rready, rready_p;
    logic       err_clr, err_clr_p;
    logic [7:0] rdata, rdata_p;
    logic       rvalid, rvalid_p;
    logic [4:0] count, count_p;
    logic       par_err, par_err_p;
    logic       frm_err, frm_err_p;
    logic       ovr, ovr_p;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(
        .CLOCK_FREQUENCY(500_000_000),
        .BAUD_RATE      (50_000_000),
        .DATA_BITS      (8),
        .PARITY         (0),
        .STOP_BITS      (1),
        .FIFO_DEPTH     (16)
    ) dut (
        .CLK         (clk),
        .NRST        (nrst),
        .UART_RX_DSER(rx),
        .RDATA       (rdata),
        .RVALID      (rvalid),
        .RREADY      (rready),
        .FIFO_COUNT  (count),
        .PARITY_ERR  (par_err),
        .FRAME_ERR   (frm_err),
        .OVERRUN     (ovr),
        .ERR_CLR     (err_clr)
    );

    uart_rx_fifo #(
        .CLOCK_FREQUENCY(500_000_000),
        .BAUD_RATE      (50_000_000),
        .DATA_BITS      (8),
        .PARITY         (2),
        .STOP_BITS      (1),
        .FIFO_DEPTH     (16)
    ) dut_p (
        .CLK         (clk),
        .NRST        (nrst),
        .UART_RX_DSER(rx_p),
        .RDATA       (rdata_p),
        .RVALID      (rvalid_p),
        .RREADY      (rready_p),
        .FIFO_COUNT  (count_p),
        .PARITY_ERR  (par_err_p),
        .FRAME_ERR   (frm_err_p),
        .OVERRUN     (ovr_p),
        .ERR_CLR     (err_clr_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive n line bits LSB first, 10 clocks each, starting on a falling edge
    task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx = bits[i];
            else rx_p = bits[i];
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_8n1(input logic [7:0] d);
        drive_bits(0, {6'h3f, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_8e1(input logic [7:0] d, input logic p);
        drive_bits(1, {5'h1f, 1'b1, p, d, 1'b0}, 11);
    endtask

    task automatic pop_one;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; rx = 1'b1; rx_p = 1'b1;
        rready = 1'b0; rready_p = 1'b0; err_clr = 1'b0; err_clr_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_count", count, 0);
        check("rst_flags", {par_err, frm_err, ovr}, 0);
        check("rst_p_flags", {rvalid_p, par_err_p, frm_err_p, ovr_p}, 0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 8N1 0xA5, check exact push latency around the mid-stop sample
        drive_bits(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 9);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        check("t1_pre_valid", rvalid, 0);
        @(negedge clk);
        check("t1_valid", rvalid, 1);
        check("t1_rdata", rdata, 8'hA5);
        check("t1_count", count, 1);
        check("t1_flags", {par_err, frm_err, ovr}, 0);
        repeat (2) @(negedge clk);
        check("t1_hold", rdata, 8'hA5);
        pop_one();
        check("t1_pop_valid", rvalid, 0);
        check("t1_pop_count", count, 0);

        // 2: 3-cycle low glitch is rejected
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t2_count", count, 0);
        check("t2_flags", {rvalid, par_err, frm_err, ovr}, 0);

        // 3: even parity, 0x03 with wrong then correct parity bit
        send_8e1(8'h03, 1'b1);
        check("t3_par_err", par_err_p, 1);
        check("t3_count0", count_p, 0);
        send_8e1(8'h03, 1'b0);
        check("t3_rdata", rdata_p, 8'h03);
        check("t3_count1", count_p, 1);
        check("t3_frm", frm_err_p, 0);

        // 4: bad stop bit, line held low; only one framing event
        drive_bits(0, {6'h00, 1'b0, 8'h55, 1'b0}, 10);
        check("t4_frm", frm_err, 1);
        check("t4_nopush", count, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_one_event", frm_err, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_nopush2", {rvalid, count}, 0);
        drive_bits(0, {6'h3f, 1'b0, 8'h55, 1'b0}, 10);
        check("t4_frm2", frm_err, 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_8n1(8'h3C);
        check("t4_rdata", rdata, 8'h3C);
        check("t4_count", count, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_clr", frm_err, 0);
        pop_one();

        // 5: overflow with 17 frames, then drain in order
        for (int i = 0; i < 17; i++) send_8n1(8'(i));
        check("t5_count", count, 16);
        check("t5_ovr", ovr, 1);
        for (int i = 0; i < 16; i++) begin
            check("t5_drain", {rvalid, rdata}, {1'b1, 8'(i)});
            pop_one();
        end
        check("t5_empty", {rvalid, count}, 0);
        rready = 1'b1;
        repeat (3) @(negedge clk);
        rready = 1'b0;
        check("t5_no_underflow", count, 0);
        check("t5_ovr_sticky", ovr, 1);

        // 6: reset mid-frame with three words queued
        send_8n1(8'h11);
        send_8n1(8'h22);
        send_8n1(8'h33);
        check("t6_count3", count, 3);
        drive_bits(0, {6'h3f, 1'b1, 8'h44, 1'b0}, 4);
        nrst = 1'b0;
        #1;
        check("t6_rvalid", rvalid, 0);
        check("t6_count", count, 0);
        check("t6_rdata", rdata, 0);
        check("t6_flags", {par_err, frm_err, ovr, par_err_p}, 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_idle", count, 0);
        send_8n1(8'h7E);
        check("t6_rdata_after", rdata, 8'h7E);
        check("t6_count_after", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
